// File: rtl/flappy_pkg.sv
// ---------------------------------------------------------------------------
// flappy_pkg
// Shared definitions for the game's random-number plumbing:
//   - state_e          : rng_arbiter FSM states (COOL, IDLE, DRAW, RETRY)
//   - RNG_W_DEFAULT    : default width of an LFSR sample / limit
//   - clog2()          : ceiling log2 used for pointer and counter widths
// ---------------------------------------------------------------------------
package flappy_pkg;

   typedef enum logic [1:0] {
      COOL  = 2'd0,
      IDLE  = 2'd1,
      DRAW  = 2'd2,
      RETRY = 2'd3
   } state_e;

   localparam int RNG_W_DEFAULT = 8;

   // Ceiling log2, never below 1 so that a 1-entry pointer or a counter
   // that only ever holds zero still gets a legal vector width.
   function automatic int clog2(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) begin
         width = width + 1;
      end
      return width;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin select: scans req starting at ptr and wrapping,
// returns the first set index.
//   req  in  N_REQ : pending requests
//   ptr  in  PTR_W : highest-priority index for this scan
//   idx  out PTR_W : chosen requester (0 when none pending)
//   any  out 1     : at least one request pending
// ---------------------------------------------------------------------------
module rr_picker #(
   parameter int N_REQ = 3,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [PTR_W-1:0] idx,
   output logic             any
);

   // Priority scan from ptr upward; the first hit wins and later hits are ignored.
   always_comb begin
      int cand_s;
      idx    = {PTR_W{1'b0}};
      any    = 1'b0;
      cand_s = 0;
      for (int i = 0; i < N_REQ; i++) begin
         cand_s = int'(ptr) + i;
         if (cand_s >= N_REQ) begin
            cand_s = cand_s - N_REQ;
         end else begin
            cand_s = cand_s;
         end
         if (!any && req[PTR_W'(cand_s)]) begin
            any = 1'b1;
            idx = PTR_W'(cand_s);
         end else begin
            any = any;
         end
      end
   end

endmodule

// File: rtl/rng_arbiter.sv
// ---------------------------------------------------------------------------
// rng_arbiter
// Shares one free-running LFSR byte stream among N_REQ requesters. Grants
// round-robin, keeps at least GAP cycles between samples (consecutive LFSR
// bytes are highly correlated) and rejection-samples into 0..lim, clamping
// to lim after RETRY_MAX rejects.
//   clk       in  1            : clock, rising edge
//   rst       in  1            : synchronous active-high reset
//   rng_in    in  RNG_W        : current LFSR byte
//   req       in  N_REQ        : level requests
//   lim       in  N_REQ*RNG_W  : packed inclusive upper bound per requester
//   gnt       out N_REQ        : one-hot grant pulse, coincident with valid
//   rand_out  out RNG_W        : delivered value, held between deliveries
//   valid     out 1            : delivery pulse
//   busy      out 1            : high while drawing or waiting to retry
// ---------------------------------------------------------------------------
module rng_arbiter
   import flappy_pkg::*;
#(
   parameter int N_REQ     = 3,
   parameter int RNG_W     = RNG_W_DEFAULT,
   parameter int GAP       = 8,
   parameter int RETRY_MAX = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [RNG_W-1:0]       rng_in,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*RNG_W-1:0] lim,
   output logic [N_REQ-1:0]       gnt,
   output logic [RNG_W-1:0]       rand_out,
   output logic                   valid,
   output logic                   busy
);

   localparam int PTR_W = clog2(N_REQ);
   localparam int CNT_W = clog2(GAP);
   localparam int RET_W = clog2(RETRY_MAX + 1);

   // COOL/RETRY run GAP-1 edges (GAP-2 down to 0) so that together with the
   // IDLE and DRAW edges the sample spacing comes out at GAP+1 / GAP.
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(GAP - 2);
   localparam logic [RET_W-1:0] RET_LAST   = RET_W'(RETRY_MAX);
   localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(N_REQ - 1);

   state_e             state_r, state_s;
   logic [CNT_W-1:0]   cnt_r, cnt_s;
   logic [PTR_W-1:0]   ptr_r, ptr_s;
   logic [PTR_W-1:0]   sel_r, sel_s;
   logic [RET_W-1:0]   retries_r, retries_s;
   logic [N_REQ-1:0]   gnt_r, gnt_s;
   logic [RNG_W-1:0]   rand_r, rand_s;
   logic               valid_r, valid_s;
   logic               busy_r, busy_s;

   logic [PTR_W-1:0]   pick_idx_s;
   logic               pick_any_s;
   logic [RNG_W-1:0]   lim_sel_s;
   logic               req_sel_s;
   logic               deliver_s;
   logic [RNG_W-1:0]   deliver_val_s;

   rr_picker #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_picker (
      .req (req),
      .ptr (ptr_r),
      .idx (pick_idx_s),
      .any (pick_any_s)
   );

   assign lim_sel_s = lim[int'(sel_r) * RNG_W +: RNG_W];
   assign req_sel_s = req[sel_r];

   // Next-state and next-output logic; delivery is flagged in the case and
   // applied once afterwards so accept and clamp share one path.
   always_comb begin
      state_s       = state_r;
      cnt_s         = cnt_r;
      ptr_s         = ptr_r;
      sel_s         = sel_r;
      retries_s     = retries_r;
      gnt_s         = {N_REQ{1'b0}};
      rand_s        = rand_r;
      valid_s       = 1'b0;
      deliver_s     = 1'b0;
      deliver_val_s = rng_in;

      case (state_r)
         COOL: begin
            if (cnt_r == CNT_W'(0)) begin
               state_s = IDLE;
            end else begin
               cnt_s = cnt_r - CNT_W'(1);
            end
         end
         IDLE: begin
            if (pick_any_s) begin
               sel_s     = pick_idx_s;
               retries_s = RET_W'(0);
               state_s   = DRAW;
            end else begin
               state_s = IDLE;
            end
         end
         DRAW: begin
            // A dropped request still burns the sample: cool down, no grant.
            if (!req_sel_s) begin
               cnt_s   = CNT_RELOAD;
               state_s = COOL;
            end else if (rng_in <= lim_sel_s) begin
               deliver_s     = 1'b1;
               deliver_val_s = rng_in;
            end else if (retries_r == RET_LAST) begin
               deliver_s     = 1'b1;
               deliver_val_s = lim_sel_s;
            end else begin
               retries_s = retries_r + RET_W'(1);
               cnt_s     = CNT_RELOAD;
               state_s   = RETRY;
            end
         end
         RETRY: begin
            if (!req_sel_s) begin
               cnt_s   = CNT_RELOAD;
               state_s = COOL;
            end else if (cnt_r == CNT_W'(0)) begin
               state_s = DRAW;
            end else begin
               cnt_s = cnt_r - CNT_W'(1);
            end
         end
         default: begin
            cnt_s   = CNT_RELOAD;
            state_s = COOL;
         end
      endcase

      if (deliver_s) begin
         rand_s  = deliver_val_s;
         valid_s = 1'b1;
         for (int i = 0; i < N_REQ; i++) begin
            gnt_s[i] = (PTR_W'(i) == sel_r);
         end
         if (sel_r == PTR_LAST) begin
            ptr_s = PTR_W'(0);
         end else begin
            ptr_s = sel_r + PTR_W'(1);
         end
         cnt_s   = CNT_RELOAD;
         state_s = COOL;
      end else begin
         rand_s = rand_s;
      end

      busy_s = (state_s == DRAW) || (state_s == RETRY);
   end

   // State and registered outputs; reset starts in COOL so the first sample
   // is at least GAP cycles after release.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= COOL;
         cnt_r     <= CNT_RELOAD;
         ptr_r     <= PTR_W'(0);
         sel_r     <= PTR_W'(0);
         retries_r <= RET_W'(0);
         gnt_r     <= {N_REQ{1'b0}};
         rand_r    <= {RNG_W{1'b0}};
         valid_r   <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         ptr_r     <= ptr_s;
         sel_r     <= sel_s;
         retries_r <= retries_s;
         gnt_r     <= gnt_s;
         rand_r    <= rand_s;
         valid_r   <= valid_s;
         busy_r    <= busy_s;
      end
   end

   assign gnt      = gnt_r;
   assign rand_out = rand_r;
   assign valid    = valid_r;
   assign busy     = busy_r;

endmodule

// File: tb/tb_rng_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rng_arbiter
// Directed bench for rng_arbiter with default parameters (3 requesters,
// 8-bit samples, GAP=8, RETRY_MAX=3). rng_in is either a bench-side LFSR or
// a scripted constant; outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_rng_arbiter;

   localparam int N_REQ     = 3;
   localparam int RNG_W     = 8;
   localparam int GAP       = 8;
   localparam int RETRY_MAX = 3;

   logic                   clk;
   logic                   rst;
   logic [RNG_W-1:0]       rng_in;
   logic [N_REQ-1:0]       req;
   logic [N_REQ*RNG_W-1:0] lim;
   logic [N_REQ-1:0]       gnt;
   logic [RNG_W-1:0]       rand_out;
   logic                   valid;
   logic                   busy;

   int         tests_run;
   int         tests_failed;
   logic [7:0] lfsr;
   logic       lfsr_en;
   logic [7:0] rng_at_edge;

   rng_arbiter #(
      .N_REQ     (N_REQ),
      .RNG_W     (RNG_W),
      .GAP       (GAP),
      .RETRY_MAX (RETRY_MAX)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rng_in   (rng_in),
      .req      (req),
      .lim      (lim),
      .gnt      (gnt),
      .rand_out (rand_out),
      .valid    (valid),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock edge; remembers the rng_in value presented at that edge.
   task automatic tick();
      rng_at_edge = rng_in;
      @(posedge clk);
      #1;
      if (lfsr_en) begin
         lfsr   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         rng_in = lfsr;
      end
   endtask

   // Ticks until valid is seen; n is the number of edges taken.
   task automatic wait_valid(input int budget, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!valid && n < budget);
   endtask

   task automatic wait_busy(input int budget, output logic ok);
      int n;
      n = 0;
      while (!busy && n < budget) begin
         tick();
         n++;
      end
      ok = busy;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick(); tick();
      tests_run++; if (gnt !== 3'b000) begin tests_failed++; $display("FAIL reset_gnt got %b want 000", gnt); end
      tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", valid); end
      tests_run++; if (rand_out !== 8'd0) begin tests_failed++; $display("FAIL reset_rand got %0d want 0", rand_out); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
   endtask

   task automatic test_first_grant();
      int n;
      req = 3'b001;
      lim = {8'd255, 8'd255, 8'd255};
      lfsr_en = 1'b1;
      rst = 1'b0;
      wait_valid(4 * GAP, n);
      tests_run++; if (n !== GAP + 1) begin tests_failed++; $display("FAIL first_latency got %0d want %0d", n, GAP + 1); end
      tests_run++; if (gnt !== 3'b001) begin tests_failed++; $display("FAIL first_gnt got %b want 001", gnt); end
      tests_run++; if (rand_out !== rng_at_edge) begin tests_failed++; $display("FAIL first_rand got %0d want %0d", rand_out, rng_at_edge); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL first_busy got %b want 0", busy); end
   endtask

   task automatic test_round_robin();
      int n;
      logic [2:0] exp_gnt [3];
      logic [7:0] held;
      exp_gnt[0] = 3'b010; exp_gnt[1] = 3'b100; exp_gnt[2] = 3'b001;
      req = 3'b111;
      for (int k = 0; k < 3; k++) begin
         wait_valid(4 * GAP, n);
         tests_run++; if (n !== GAP + 1) begin tests_failed++; $display("FAIL rr_spacing[%0d] got %0d want %0d", k, n, GAP + 1); end
         tests_run++; if (gnt !== exp_gnt[k]) begin tests_failed++; $display("FAIL rr_gnt[%0d] got %b want %b", k, gnt, exp_gnt[k]); end
         tests_run++; if (rand_out !== rng_at_edge) begin tests_failed++; $display("FAIL rr_rand[%0d] got %0d want %0d", k, rand_out, rng_at_edge); end
      end
      held = rand_out;
      tick();
      tests_run++; if (valid !== 1'b0 || gnt !== 3'b000) begin tests_failed++; $display("FAIL pulse_drop got valid=%b gnt=%b want 0/000", valid, gnt); end
      tests_run++; if (rand_out !== held) begin tests_failed++; $display("FAIL rand_hold got %0d want %0d", rand_out, held); end
   endtask

   task automatic test_clamp();
      int n;
      logic ok;
      req = 3'b001;
      lim = {8'd255, 8'd255, 8'd0};
      lfsr_en = 1'b0;
      rng_in = 8'hA5;
      wait_busy(4 * GAP, ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL clamp_busy got %b want 1", ok); end
      wait_valid(6 * GAP, n);
      tests_run++; if (n !== 1 + RETRY_MAX * GAP) begin tests_failed++; $display("FAIL clamp_latency got %0d want %0d", n, 1 + RETRY_MAX * GAP); end
      tests_run++; if (rand_out !== 8'd0) begin tests_failed++; $display("FAIL clamp_rand got %0d want 0", rand_out); end
      tests_run++; if (gnt !== 3'b001) begin tests_failed++; $display("FAIL clamp_gnt got %b want 001", gnt); end
   endtask

   task automatic test_retry_accept();
      int seen;
      logic ok;
      req = 3'b010;
      lim = {8'd255, 8'd127, 8'd0};
      rng_in = 8'd200;
      wait_busy(4 * GAP, ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL retry_busy got %b want 1", ok); end
      tick();
      tests_run++; if (valid !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL retry_reject got valid=%b busy=%b want 0/1", valid, busy); end
      seen = 0;
      for (int i = 0; i < GAP - 1; i++) begin
         tick();
         if (valid) seen++;
      end
      tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL retry_early got %0d valids want 0", seen); end
      rng_in = 8'd50;
      tick();
      tests_run++; if (valid !== 1'b1) begin tests_failed++; $display("FAIL retry_valid got %b want 1", valid); end
      tests_run++; if (rand_out !== 8'd50) begin tests_failed++; $display("FAIL retry_rand got %0d want 50", rand_out); end
      tests_run++; if (gnt !== 3'b010) begin tests_failed++; $display("FAIL retry_gnt got %b want 010", gnt); end
   endtask

   task automatic test_abort();
      int n;
      int seen;
      logic ok;
      req = 3'b001;
      lim = {8'd255, 8'd255, 8'd10};
      rng_in = 8'd200;
      wait_busy(4 * GAP, ok);
      tick(); tick(); tick();
      req = 3'b000;
      tick();
      tests_run++; if (valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL abort_state got valid=%b busy=%b want 0/0", valid, busy); end
      seen = 0;
      for (int i = 0; i < 2 * GAP; i++) begin
         tick();
         if (valid) seen++;
      end
      tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL abort_novalid got %0d valids want 0", seen); end
      req = 3'b111;
      lim = {8'd255, 8'd255, 8'd255};
      lfsr_en = 1'b1;
      wait_valid(4 * GAP, n);
      tests_run++; if (n !== 2) begin tests_failed++; $display("FAIL abort_latency got %0d want 2", n); end
      tests_run++; if (gnt !== 3'b100) begin tests_failed++; $display("FAIL abort_ptr got %b want 100", gnt); end
   endtask

   task automatic test_reset_mid_draw();
      int n;
      logic ok;
      req = 3'b001;
      wait_busy(4 * GAP, ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL rstdraw_busy got %b want 1", ok); end
      rst = 1'b1;
      tick();
      tests_run++; if (valid !== 1'b0 || gnt !== 3'b000 || rand_out !== 8'd0 || busy !== 1'b0) begin
         tests_failed++; $display("FAIL rstdraw_outs got valid=%b gnt=%b rand=%0d busy=%b want all 0", valid, gnt, rand_out, busy);
      end
      rst = 1'b0;
      wait_valid(4 * GAP, n);
      tests_run++; if (n !== GAP + 1) begin tests_failed++; $display("FAIL rstdraw_latency got %0d want %0d", n, GAP + 1); end
      tests_run++; if (gnt !== 3'b001) begin tests_failed++; $display("FAIL rstdraw_gnt got %b want 001", gnt); end
   endtask

   task automatic test_bounds();
      logic ok;
      lfsr_en = 1'b0;
      req = 3'b001;
      lim = {8'd255, 8'd255, 8'd0};
      rng_in = 8'd0;
      wait_busy(4 * GAP, ok);
      tick();
      tests_run++; if (valid !== 1'b1 || rand_out !== 8'd0 || gnt !== 3'b001) begin
         tests_failed++; $display("FAIL lim0_accept got valid=%b rand=%0d gnt=%b want 1/0/001", valid, rand_out, gnt);
      end
      req = 3'b100;
      rng_in = 8'd255;
      wait_busy(4 * GAP, ok);
      tick();
      tests_run++; if (valid !== 1'b1 || rand_out !== 8'd255 || gnt !== 3'b100) begin
         tests_failed++; $display("FAIL lim255_accept got valid=%b rand=%0d gnt=%b want 1/255/100", valid, rand_out, gnt);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      lfsr         = 8'h01;
      lfsr_en      = 1'b0;
      rng_in       = 8'd0;
      rng_at_edge  = 8'd0;
      req          = 3'b000;
      lim          = {8'd255, 8'd255, 8'd255};
      rst          = 1'b1;

      test_reset();
      test_first_grant();
      test_round_robin();
      test_clamp();
      test_retry_accept();
      test_abort();
      test_reset_mid_draw();
      test_bounds();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
